// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares the byte-wide RAM/IO bus between instruction fetch
// and the data port. Each granted 1/2/4-byte access is split into byte beats.
// RAM read data arrives one cycle after the address, so reads finish one beat later.
// Optional feature macro: RAM_ARB_FAIR_EN selects round-robin arbitration on conflicts.
// When it is undefined, data always wins over fetch.
// Handshake: a requester raises *_req and holds it until its one-cycle *_done pulse.
// The request fields are captured at the grant edge and ignored after that edge.
// Only a fetch can be withdrawn, using if_flush.
module ram_bus_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              if_busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr,
    input  logic              io_buffer_full,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, IF_RD, D_RD, D_WR} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf;
    logic [ADDR_W-1:0] ram_a_q;
    logic              wr_q;
    logic              rdy_q;

    logic              req_if;
    logic              grant_d;
    logic              grant_if;
    logic              io_block;
    logic              replay;
    logic [2:0]        cnt_m1;
    logic [1:0]        byte_idx;
    logic [1:0]        wb_idx;
    logic [2:0]        d_n;
    logic [ADDR_W-1:0] beat_next;
    logic [31:0]       merged;

    assign req_if    = if_req && !if_flush;
    assign io_block  = (state == D_WR) && (addr_q[17:16] == IO_SEL) && io_buffer_full;
    assign cnt_m1    = cnt - 3'd1;
    assign byte_idx  = cnt_m1[1:0];
    assign wb_idx    = 2'(cnt + 3'd1);
    assign beat_next = addr_q + ADDR_W'(cnt) + ADDR_W'(1);
    assign d_n       = (d_size == 2'd0) ? 3'd1 : (d_size == 2'd1) ? 3'd2 : 3'd4;
    assign dbg_state = state;

    // While frozen the RAM keeps reading the held address, so the byte in flight is lost.
    // The first active cycle after a freeze re-drives the previous beat's address and
    // holds all state, so the pending capture sees the correct byte one cycle later.
    assign replay = rdy && !rdy_q && (state == IF_RD || state == D_RD) && (cnt != 3'd0);

`ifdef RAM_ARB_FAIR_EN
    logic last_d;
    assign grant_d = d_req && !(req_if && last_d);
`else
    assign grant_d = d_req;
`endif
    assign grant_if = req_if && !grant_d;

    // Bus pins: replayed address on resume, and no write while frozen or the UART is full.
    assign ram_a  = replay ? (addr_q + ADDR_W'(cnt_m1)) : ram_a_q;
    assign ram_wr = wr_q && rdy && !io_block;

    // Read buffer with the byte arriving this cycle merged into its lane.
    always_comb begin
        merged = rbuf;
        merged[8*byte_idx +: 8] = ram_din;
    end

`ifdef RAM_ARB_FAIR_EN
    // Remember which port won the latest grant so that conflicts alternate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (rdy && state == IDLE && !if_done && !d_done && (grant_d || grant_if)) begin
            last_d <= grant_d;
        end
    end
`endif

    // Main sequencer: grant, byte beats, capture, done pulses and freeze handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            nbytes   <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf     <= '0;
            ram_a_q  <= '0;
            wr_q     <= 1'b0;
            ram_dout <= '0;
            if_data  <= '0;
            if_done  <= 1'b0;
            d_rdata  <= '0;
            d_done   <= 1'b0;
            if_busy  <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            rdy_q <= rdy;
            if (rdy && !replay) begin
                if_done <= 1'b0;
                d_done  <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!if_done && !d_done) begin
                            if (grant_d) begin
                                state    <= d_we ? D_WR : D_RD;
                                addr_q   <= d_addr;
                                wdata_q  <= d_wdata;
                                nbytes   <= d_n;
                                cnt      <= 3'd0;
                                rbuf     <= '0;
                                ram_a_q  <= d_addr;
                                ram_dout <= d_wdata[7:0];
                                wr_q     <= d_we;
                            end else if (grant_if) begin
                                state    <= IF_RD;
                                addr_q   <= if_addr;
                                nbytes   <= 3'd4;
                                cnt      <= 3'd0;
                                rbuf     <= '0;
                                ram_a_q  <= if_addr;
                                wr_q     <= 1'b0;
                                if_busy  <= 1'b1;
                            end
                        end
                    end
                    IF_RD, D_RD: begin
                        if (state == IF_RD && if_flush) begin
                            state   <= IDLE;
                            if_busy <= 1'b0;
                        end else begin
                            if (cnt != 3'd0) begin
                                rbuf <= merged;
                            end
                            if (cnt + 3'd1 < nbytes) begin
                                ram_a_q <= beat_next;
                            end
                            if (cnt == nbytes) begin
                                state   <= IDLE;
                                if_busy <= 1'b0;
                                if (state == IF_RD) begin
                                    if_data <= merged;
                                    if_done <= 1'b1;
                                end else begin
                                    d_rdata <= merged;
                                    d_done  <= 1'b1;
                                end
                            end
                            cnt <= cnt + 3'd1;
                        end
                    end
                    D_WR: begin
                        if (!io_block) begin
                            if (cnt + 3'd1 == nbytes) begin
                                state  <= IDLE;
                                wr_q   <= 1'b0;
                                d_done <= 1'b1;
                            end else begin
                                ram_a_q  <= beat_next;
                                ram_dout <= wdata_q[8*wb_idx +: 8];
                                cnt      <= cnt + 3'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
